// File: rtl/jk_sr_pkg.sv
// Shared encodings for the SR core that sits under the JK flip-flop.
// The SR command is encoded as {s,r}.
package jk_sr_pkg;

    localparam logic [1:0] SR_HOLD    = 2'b00;
    localparam logic [1:0] SR_RESET   = 2'b01;
    localparam logic [1:0] SR_SET     = 2'b10;
    localparam logic [1:0] SR_ILLEGAL = 2'b11;

endpackage

// File: rtl/jk_using_sr_sr_ff.sv
// Clocked SR flip-flop, WIDTH independent lanes, synchronous active-high reset.
// Holds the only state register of the JK flip-flop.
module sr_ff
    import jk_sr_pkg::*;
#(
    parameter int unsigned WIDTH   = 1,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] s,
    input  logic [WIDTH-1:0] r,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);

    logic [WIDTH-1:0] q_q;
    logic [WIDTH-1:0] q_d;

    always_comb begin
        q_d = q_q;
        for (int i = 0; i < WIDTH; i++) begin
            unique case ({s[i], r[i]})
                SR_HOLD:    q_d[i] = q_q[i];
                SR_RESET:   q_d[i] = 1'b0;
                SR_SET:     q_d[i] = 1'b1;
                SR_ILLEGAL: q_d[i] = q_q[i];
                default:    q_d[i] = q_q[i];
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            q_q <= {WIDTH{RST_VAL}};
        end else begin
            q_q <= q_d;
        end
    end

    // qbar comes from the same register so it can never disagree with q.
    assign q    = q_q;
    assign qbar = ~q_q;

    a_no_sr_illegal: assert property (
        @(posedge clock) disable iff (reset) ~|(s & r)
    );

endmodule

// File: rtl/jk_using_sr.sv
// Edge-triggered JK flip-flop: J/K are steered through the current state
// into an SR core so that S and R are never asserted together.
module jk_using_sr
    import jk_sr_pkg::*;
#(
    parameter int unsigned WIDTH   = 1,
    parameter logic        RST_VAL = 1'b0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] j,
    input  logic [WIDTH-1:0] k,
    output logic [WIDTH-1:0] q,
    output logic [WIDTH-1:0] qbar
);

    logic [WIDTH-1:0] s;
    logic [WIDTH-1:0] r;

    // Set only from 0 and reset only from 1; j=k=1 therefore toggles.
    assign s = j & ~q;
    assign r = k & q;

    sr_ff #(
        .WIDTH  (WIDTH),
        .RST_VAL(RST_VAL)
    ) u_sr_ff (
        .clock(clock),
        .reset(reset),
        .s    (s),
        .r    (r),
        .q    (q),
        .qbar (qbar)
    );

endmodule

// File: tb/tb_jk_using_sr.sv
// Directed bench for jk_using_sr with a JK-table model checked every cycle.
// Four lanes; most tests drive all lanes identically.
module tb_jk_using_sr;

    localparam int W = 4;
    localparam logic [W-1:0] F = '1;
    localparam logic [W-1:0] Z = '0;

    logic         clock;
    logic         reset;
    logic [W-1:0] j;
    logic [W-1:0] k;
    logic [W-1:0] q;
    logic [W-1:0] qbar;

    int passed = 0;
    int total  = 0;

    logic [W-1:0] m_q;
    bit           m_valid = 0;

    jk_using_sr #(
        .WIDTH  (W),
        .RST_VAL(1'b0)
    ) dut (
        .clock(clock),
        .reset(reset),
        .j    (j),
        .k    (k),
        .q    (q),
        .qbar (qbar)
    );

    initial clock = 1'b0;
    always #10 clock = ~clock;

    task automatic check(input string name, input logic [W-1:0] act,
                         input logic [W-1:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    // Reference: per-lane JK characteristic table.
    always @(posedge clock) begin
        if (reset) begin
            m_q = Z;
            m_valid = 1;
        end else if (m_valid) begin
            for (int i = 0; i < W; i++) begin
                case ({j[i], k[i]})
                    2'b00: m_q[i] = m_q[i];
                    2'b01: m_q[i] = 1'b0;
                    2'b10: m_q[i] = 1'b1;
                    default: m_q[i] = !m_q[i];
                endcase
            end
        end
    end

    always @(negedge clock) begin
        if (m_valid) begin
            check("model_q", q, m_q);
            check("model_qbar", qbar, ~m_q);
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        j = Z;
        k = Z;
        repeat (3) tick();
        check("reset_q", q, Z);
        check("reset_qbar", qbar, F);

        reset = 1'b0;
        repeat (3) tick();
        check("hold_q", q, Z);

        j = F; k = Z;
        tick();
        check("set_q", q, F);
        check("set_qbar", qbar, Z);
        repeat (2) tick();
        check("set_stay", q, F);

        j = Z; k = F;
        tick();
        check("clr_q", q, Z);
        check("clr_qbar", qbar, F);
        tick();
        check("clr_stay", q, Z);

        j = F; k = F;
        for (int i = 0; i < 6; i++) begin
            tick();
            check($sformatf("toggle_%0d", i), q, (i % 2 == 0) ? F : Z);
        end

        tick();
        check("pre_rst_q", q, F);
        reset = 1'b1;
        tick();
        check("rst_wins", q, Z);
        reset = 1'b0;
        tick();
        check("resume", q, F);

        reset = 1'b1;
        j = Z; k = Z;
        tick();
        reset = 1'b0;
        j = 4'b1010;
        k = 4'b0110;
        tick();
        check("mix_1", q, 4'b1010);
        check("mix_1_qbar", qbar, 4'b0101);
        tick();
        check("mix_2", q, 4'b1000);

        j = Z; k = Z;
        tick();
        @(negedge clock);
        #1;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule
